// File: rtl/alu_rs.sv
// ALU reservation station. Holds dispatched instructions until both operands are
// available, snoops the CDB for results, and issues the lowest-index ready entry each cycle.
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [2:0]         in_op,
  input  logic [6:0]         in_op_type,
  input  logic               in_op_addition,
  input  logic [ROB_BIT-1:0] in_rob_entry,
  input  logic [31:0]        in_vi,
  input  logic [31:0]        in_vj,
  input  logic [ROB_BIT-1:0] in_qi,
  input  logic [ROB_BIT-1:0] in_qj,
  input  logic               in_qi_busy,
  input  logic               in_qj_busy,
  input  logic               cdb_valid,
  input  logic [ROB_BIT-1:0] cdb_rob,
  input  logic [31:0]        cdb_val,
  output logic               full,
  output logic               alu_valid,
  output logic [31:0]        alu_vi,
  output logic [31:0]        alu_vj,
  output logic [2:0]         alu_op,
  output logic [6:0]         alu_op_type,
  output logic               alu_op_addition,
  output logic [ROB_BIT-1:0] alu_rob_entry
);

  localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] qib_q, qib_d, qjb_q, qjb_d;
  logic [RS_SIZE-1:0] ready;
  logic [2:0]         op_q   [RS_SIZE];
  logic [2:0]         op_d   [RS_SIZE];
  logic [6:0]         typ_q  [RS_SIZE];
  logic [6:0]         typ_d  [RS_SIZE];
  logic               add_q  [RS_SIZE];
  logic               add_d  [RS_SIZE];
  logic [ROB_BIT-1:0] rob_q  [RS_SIZE];
  logic [ROB_BIT-1:0] rob_d  [RS_SIZE];
  logic [31:0]        vi_q   [RS_SIZE];
  logic [31:0]        vi_d   [RS_SIZE];
  logic [31:0]        vj_q   [RS_SIZE];
  logic [31:0]        vj_d   [RS_SIZE];
  logic [ROB_BIT-1:0] qi_q   [RS_SIZE];
  logic [ROB_BIT-1:0] qi_d   [RS_SIZE];
  logic [ROB_BIT-1:0] qj_q   [RS_SIZE];
  logic [ROB_BIT-1:0] qj_d   [RS_SIZE];

  logic               alu_valid_q, alu_valid_d;
  logic [31:0]        alu_vi_q, alu_vi_d, alu_vj_q, alu_vj_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [6:0]         alu_typ_q, alu_typ_d;
  logic               alu_add_q, alu_add_d;
  logic [ROB_BIT-1:0] alu_rob_q, alu_rob_d;

  logic               iss_hit;
  logic [IW-1:0]      iss_idx, free_idx;
  logic               byp_i, byp_j;

  function automatic logic tag_hit(input logic wait_bit, input logic [ROB_BIT-1:0] tag,
                                   input logic bcast, input logic [ROB_BIT-1:0] btag);
    return wait_bit && bcast && (tag == btag);
  endfunction

  assign ready = busy_q & ~qib_q & ~qjb_q;
  assign full  = &busy_q;

  // Priority encoders: scanning downward leaves the lowest matching index.
  always_comb begin
    iss_hit  = 1'b0;
    iss_idx  = '0;
    free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        iss_hit = 1'b1;
        iss_idx = IW'(i);
      end
      if (!busy_q[i]) free_idx = IW'(i);
    end
  end

  assign byp_i = tag_hit(in_qi_busy, in_qi, cdb_valid, cdb_rob);
  assign byp_j = tag_hit(in_qj_busy, in_qj, cdb_valid, cdb_rob);

  always_comb begin
    busy_d      = busy_q;
    qib_d       = qib_q;
    qjb_d       = qjb_q;
    op_d        = op_q;
    typ_d       = typ_q;
    add_d       = add_q;
    rob_d       = rob_q;
    vi_d        = vi_q;
    vj_d        = vj_q;
    qi_d        = qi_q;
    qj_d        = qj_q;
    alu_valid_d = alu_valid_q;
    alu_vi_d    = alu_vi_q;
    alu_vj_d    = alu_vj_q;
    alu_op_d    = alu_op_q;
    alu_typ_d   = alu_typ_q;
    alu_add_d   = alu_add_q;
    alu_rob_d   = alu_rob_q;

    if (rdy_in) begin
      if (clear) begin
        busy_d      = '0;
        alu_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && tag_hit(qib_q[i], qi_q[i], cdb_valid, cdb_rob)) begin
            vi_d[i]  = cdb_val;
            qib_d[i] = 1'b0;
          end
          if (busy_q[i] && tag_hit(qjb_q[i], qj_q[i], cdb_valid, cdb_rob)) begin
            vj_d[i]  = cdb_val;
            qjb_d[i] = 1'b0;
          end
        end

        alu_valid_d = iss_hit;
        if (iss_hit) begin
          alu_vi_d         = vi_q[iss_idx];
          alu_vj_d         = vj_q[iss_idx];
          alu_op_d         = op_q[iss_idx];
          alu_typ_d        = typ_q[iss_idx];
          alu_add_d        = add_q[iss_idx];
          alu_rob_d        = rob_q[iss_idx];
          busy_d[iss_idx]  = 1'b0;
        end

        // The free slot comes from pre-issue state, so a slot vacated this cycle is never refilled.
        if (in_valid && !full) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = in_op;
          typ_d[free_idx]  = in_op_type;
          add_d[free_idx]  = in_op_addition;
          rob_d[free_idx]  = in_rob_entry;
          qi_d[free_idx]   = in_qi;
          qj_d[free_idx]   = in_qj;
          vi_d[free_idx]   = byp_i ? cdb_val : in_vi;
          vj_d[free_idx]   = byp_j ? cdb_val : in_vj;
          qib_d[free_idx]  = in_qi_busy && !byp_i;
          qjb_d[free_idx]  = in_qj_busy && !byp_j;
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy_q      <= '0;
      alu_valid_q <= 1'b0;
      alu_vi_q    <= '0;
      alu_vj_q    <= '0;
      alu_op_q    <= '0;
      alu_typ_q   <= '0;
      alu_add_q   <= 1'b0;
      alu_rob_q   <= '0;
    end else begin
      busy_q      <= busy_d;
      alu_valid_q <= alu_valid_d;
      alu_vi_q    <= alu_vi_d;
      alu_vj_q    <= alu_vj_d;
      alu_op_q    <= alu_op_d;
      alu_typ_q   <= alu_typ_d;
      alu_add_q   <= alu_add_d;
      alu_rob_q   <= alu_rob_d;
    end
  end

  // Entry payload is only meaningful under busy, so it carries no reset.
  always_ff @(posedge clk_in) begin
    qib_q <= qib_d;
    qjb_q <= qjb_d;
    op_q  <= op_d;
    typ_q <= typ_d;
    add_q <= add_d;
    rob_q <= rob_d;
    vi_q  <= vi_d;
    vj_q  <= vj_d;
    qi_q  <= qi_d;
    qj_q  <= qj_d;
  end

  assign alu_valid       = alu_valid_q;
  assign alu_vi          = alu_vi_q;
  assign alu_vj          = alu_vj_q;
  assign alu_op          = alu_op_q;
  assign alu_op_type     = alu_typ_q;
  assign alu_op_addition = alu_add_q;
  assign alu_rob_entry   = alu_rob_q;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, all checked against
// an entry-table reference model of the reservation station.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, in_valid;
  logic [2:0]  in_op;
  logic [6:0]  in_op_type;
  logic        in_op_addition;
  logic [3:0]  in_rob_entry, in_qi, in_qj, cdb_rob;
  logic [31:0] in_vi, in_vj, cdb_val;
  logic        in_qi_busy, in_qj_busy, cdb_valid;
  logic        full, alu_valid, alu_op_addition;
  logic [31:0] alu_vi, alu_vj;
  logic [2:0]  alu_op;
  logic [6:0]  alu_op_type;
  logic [3:0]  alu_rob_entry;

  int n_chk = 0;
  int n_err = 0;

  alu_rs #(.RS_SIZE(8), .ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear), .in_valid(in_valid),
    .in_op(in_op), .in_op_type(in_op_type), .in_op_addition(in_op_addition),
    .in_rob_entry(in_rob_entry), .in_vi(in_vi), .in_vj(in_vj), .in_qi(in_qi), .in_qj(in_qj),
    .in_qi_busy(in_qi_busy), .in_qj_busy(in_qj_busy), .cdb_valid(cdb_valid),
    .cdb_rob(cdb_rob), .cdb_val(cdb_val), .full(full), .alu_valid(alu_valid),
    .alu_vi(alu_vi), .alu_vj(alu_vj), .alu_op(alu_op), .alu_op_type(alu_op_type),
    .alu_op_addition(alu_op_addition), .alu_rob_entry(alu_rob_entry)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit        busy;
    bit [2:0]  op;
    bit [6:0]  typ;
    bit        add;
    bit [3:0]  rob;
    bit [31:0] vi, vj;
    bit [3:0]  qi, qj;
    bit        wi, wj;
  } ent_t;

  ent_t      m_rs [8];
  bit        m_valid;
  bit [31:0] m_vi, m_vj;
  bit [2:0]  m_op;
  bit [6:0]  m_typ;
  bit        m_add;
  bit [3:0]  m_rob;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_full();
    foreach (m_rs[i]) if (!m_rs[i].busy) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m_rs[i]) m_rs[i].busy = 1'b0;
    m_valid = 0; m_vi = 0; m_vj = 0; m_op = 0; m_typ = 0; m_add = 0; m_rob = 0;
  endtask

  // One clock edge of the reference station, using the inputs as sampled at that edge.
  task automatic model_step();
    ent_t nxt [8];
    ent_t e;
    int   iss, fr;
    bit   was_full;
    if (!rst_in) begin model_reset(); return; end
    if (!rdy_in) return;
    if (clear) begin
      foreach (m_rs[i]) m_rs[i].busy = 1'b0;
      m_valid = 0;
      return;
    end
    was_full = m_full();
    iss = -1; fr = -1;
    foreach (m_rs[i]) begin
      if (iss < 0 && m_rs[i].busy && !m_rs[i].wi && !m_rs[i].wj) iss = i;
      if (fr < 0 && !m_rs[i].busy) fr = i;
    end
    nxt = m_rs;
    foreach (nxt[i]) begin
      if (cdb_valid && nxt[i].busy && nxt[i].wi && nxt[i].qi == cdb_rob) begin
        nxt[i].vi = cdb_val; nxt[i].wi = 0;
      end
      if (cdb_valid && nxt[i].busy && nxt[i].wj && nxt[i].qj == cdb_rob) begin
        nxt[i].vj = cdb_val; nxt[i].wj = 0;
      end
    end
    m_valid = (iss >= 0);
    if (iss >= 0) begin
      m_vi = m_rs[iss].vi; m_vj = m_rs[iss].vj; m_op = m_rs[iss].op;
      m_typ = m_rs[iss].typ; m_add = m_rs[iss].add; m_rob = m_rs[iss].rob;
      nxt[iss].busy = 0;
    end
    if (in_valid && !was_full) begin
      e.busy = 1; e.op = in_op; e.typ = in_op_type; e.add = in_op_addition;
      e.rob = in_rob_entry; e.qi = in_qi; e.qj = in_qj;
      e.wi = in_qi_busy && !(cdb_valid && in_qi == cdb_rob);
      e.wj = in_qj_busy && !(cdb_valid && in_qj == cdb_rob);
      e.vi = (in_qi_busy && !e.wi) ? cdb_val : in_vi;
      e.vj = (in_qj_busy && !e.wj) ? cdb_val : in_vj;
      nxt[fr] = e;
    end
    m_rs = nxt;
  endtask

  task automatic compare_all();
    chk("full",      64'(full),            64'(m_full()));
    chk("alu_valid", 64'(alu_valid),       64'(m_valid));
    chk("alu_vi",    64'(alu_vi),          64'(m_vi));
    chk("alu_vj",    64'(alu_vj),          64'(m_vj));
    chk("alu_op",    64'(alu_op),          64'(m_op));
    chk("alu_type",  64'(alu_op_type),     64'(m_typ));
    chk("alu_add",   64'(alu_op_addition), 64'(m_add));
    chk("alu_rob",   64'(alu_rob_entry),   64'(m_rob));
  endtask

  task automatic step();
    @(posedge clk_in);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rdy_in = 1; clear = 0; in_valid = 0; cdb_valid = 0;
  endtask

  task automatic disp(input bit wi, input bit [3:0] qi, input bit wj, input bit [3:0] qj,
                      input bit [31:0] vi, input bit [31:0] vj, input bit [3:0] rob);
    in_valid = 1; in_op = 3'b000; in_op_type = 7'b0110011; in_op_addition = 0;
    in_qi_busy = wi; in_qi = qi; in_qj_busy = wj; in_qj = qj;
    in_vi = vi; in_vj = vj; in_rob_entry = rob;
  endtask

  initial begin
    rst_in = 0; idle();
    in_op = 0; in_op_type = 0; in_op_addition = 0; in_rob_entry = 0;
    in_vi = 0; in_vj = 0; in_qi = 0; in_qj = 0; in_qi_busy = 0; in_qj_busy = 0;
    cdb_rob = 0; cdb_val = 0;
    model_reset();
    #2;
    chk("rst_valid", 64'(alu_valid), 64'd0);
    chk("rst_full",  64'(full),      64'd0);
    chk("rst_vi",    64'(alu_vi),    64'd0);
    step(); step();
    rst_in = 1;

    // Ready operands issue one edge after dispatch.
    disp(0, 0, 0, 0, 5, 3, 2); step();
    idle(); step();
    chk("t30_valid", 64'(alu_valid), 64'd1);
    chk("t30_vi", 64'(alu_vi), 64'd5);
    chk("t30_vj", 64'(alu_vj), 64'd3);
    chk("t30_rob", 64'(alu_rob_entry), 64'd2);
    step();
    chk("t30_drop", 64'(alu_valid), 64'd0);

    // CDB wakeup two cycles after dispatch, then same-cycle bypass.
    disp(1, 7, 0, 0, 0, 9, 3); step();
    idle(); step();
    cdb_valid = 1; cdb_rob = 7; cdb_val = 32'h1234; step();
    chk("t31_wait", 64'(alu_valid), 64'd0);
    idle(); step();
    chk("t31_valid", 64'(alu_valid), 64'd1);
    chk("t31_vi", 64'(alu_vi), 64'h1234);
    disp(1, 7, 0, 0, 0, 9, 4); cdb_valid = 1; cdb_rob = 7; cdb_val = 32'h1234; step();
    idle(); step();
    chk("t31_byp_valid", 64'(alu_valid), 64'd1);
    chk("t31_byp_vi", 64'(alu_vi), 64'h1234);

    // Fill every entry, drop an overflow dispatch, then drain in index order.
    for (int i = 0; i < 8; i++) begin
      disp(1, 9, 0, 0, 0, i, 4'(i)); step();
    end
    chk("t32_full", 64'(full), 64'd1);
    disp(0, 0, 0, 0, 1, 1, 15); step();
    chk("t32_full_hold", 64'(full), 64'd1);
    idle(); cdb_valid = 1; cdb_rob = 9; cdb_val = 32'hABCD; step();
    idle();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t32_order", 64'(alu_rob_entry), 64'(i));
      chk("t32_issue", 64'(alu_valid), 64'd1);
      chk("t32_full_drop", 64'(full), 64'd0);
    end
    step();
    chk("t32_empty", 64'(alu_valid), 64'd0);

    // Flush discards waiting entries and the in-flight issue.
    for (int i = 0; i < 3; i++) begin
      disp(1, 5, 0, 0, 0, 0, 4'(i)); step();
    end
    disp(0, 0, 0, 0, 7, 7, 6); step();
    idle(); step();
    chk("t33_pre", 64'(alu_valid), 64'd1);
    clear = 1; step();
    chk("t33_valid", 64'(alu_valid), 64'd0);
    chk("t33_full", 64'(full), 64'd0);
    idle(); cdb_valid = 1; cdb_rob = 5; step();
    idle(); step(); step();
    chk("t33_no_issue", 64'(alu_valid), 64'd0);

    // Stall with a ready entry and a lost CDB pulse.
    disp(1, 6, 0, 0, 0, 0, 2); step();
    disp(0, 0, 0, 0, 11, 12, 1); step();
    idle(); rdy_in = 0;
    for (int i = 0; i < 4; i++) begin
      cdb_valid = (i == 1); cdb_rob = 6; cdb_val = 32'h66;
      step();
      chk("t34_frozen", 64'(alu_valid), 64'd0);
    end
    idle(); step();
    chk("t34_resume", 64'(alu_valid), 64'd1);
    chk("t34_rob", 64'(alu_rob_entry), 64'd1);
    step();
    chk("t34_lost_cdb", 64'(alu_valid), 64'd0);
    clear = 1; step(); idle();

    // Asynchronous reset mid-issue.
    disp(0, 0, 0, 0, 1, 2, 3); step();
    disp(0, 0, 0, 0, 4, 5, 6); step();
    chk("t35_pre", 64'(alu_valid), 64'd1);
    #3 rst_in = 0;
    #1;
    model_reset();
    chk("t35_valid", 64'(alu_valid), 64'd0);
    chk("t35_full", 64'(full), 64'd0);
    chk("t35_vi", 64'(alu_vi), 64'd0);
    step();
    rst_in = 1; idle();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rdy_in         = ($urandom_range(9) != 0);
      clear          = ($urandom_range(39) == 0);
      in_valid       = 1'($urandom_range(1));
      in_op          = 3'($urandom);
      in_op_type     = 7'($urandom);
      in_op_addition = 1'($urandom);
      in_rob_entry   = 4'($urandom);
      in_vi          = $urandom;
      in_vj          = $urandom;
      in_qi          = 4'($urandom);
      in_qj          = 4'($urandom);
      in_qi_busy     = 1'($urandom);
      in_qj_busy     = 1'($urandom);
      cdb_valid      = 1'($urandom);
      cdb_rob        = 4'($urandom);
      cdb_val        = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 SHALL have parameter RS_SIZE, default 8, number of reservation-station entries (power of two, 2..16).
REQ-002 SHALL have parameter ROB_BIT, default 4, ROB tag width.
REQ-003 SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rdy_in  input  1  ready; when low the block pauses.
REQ-006 SHALL have port clear  input  1  flush (branch mispredict); discards all entries.
REQ-007 SHALL have port in_valid  input  1  dispatch request for one instruction.
REQ-008 SHALL have ports in_op (3), in_op_type (7), in_op_addition (1), in_rob_entry (ROB_BIT), all inputs: the instruction's ALU fields.
REQ-009 SHALL have ports in_vi, in_vj  input  32 each  operand values, valid when the matching busy bit is 0.
REQ-010 SHALL have ports in_qi, in_qj  input  ROB_BIT each  producer tags; in_qi_busy, in_qj_busy  input  1 each  operand not yet available.
REQ-011 SHALL have ports cdb_valid (1), cdb_rob (ROB_BIT), cdb_val (32), all inputs: result broadcast.
REQ-012 SHALL have port full  output  1  all entries occupied.
REQ-013 SHALL have ports alu_valid (1), alu_vi (32), alu_vj (32), alu_op (3), alu_op_type (7), alu_op_addition (1), alu_rob_entry (ROB_BIT), all registered outputs: the issue to the ALU.

Function
REQ-014 Each entry SHALL hold busy, op fields, rob tag, vi/vj, qi/qj, and qi_busy/qj_busy.
REQ-015 full SHALL be combinational from registered state: 1 if and only if every entry is busy.
REQ-016 When rdy_in=0, all state and outputs SHALL hold, and all inputs (including cdb_*) SHALL be ignored.
REQ-017 When rdy_in=1 and clear=1, every busy bit SHALL be set to 0 and alu_valid SHALL be set to 0; dispatch, wakeup and issue in that cycle SHALL be ignored.
REQ-018 Dispatch: when rdy_in=1, clear=0, in_valid=1 and full=0, the block SHALL write the instruction into the lowest-index non-busy entry and set that entry's busy bit.
REQ-019 When in_valid=1 and full=1, the instruction SHALL be dropped with no state change (upstream must not do this; verification flags it).
REQ-020 Dispatch bypass: if cdb_valid=1 and an incoming busy operand's tag equals cdb_rob, that operand SHALL be stored as cdb_val with its busy bit cleared.
REQ-021 Wakeup: on each active cycle with cdb_valid=1, every busy entry whose qi_busy=1 and qi=cdb_rob SHALL take vi=cdb_val and clear qi_busy; vj/qj SHALL be handled the same way independently (both operands may wake in the same cycle).
REQ-022 An entry SHALL be ready when busy=1, qi_busy=0 and qj_busy=0, evaluated on registered state only.
REQ-023 Issue: on each active non-clear cycle, the lowest-index ready entry SHALL be driven onto the alu_* registers with alu_valid=1, and its busy bit SHALL be cleared at the same edge.
REQ-024 At most one issue SHALL occur per cycle; if no entry is ready, alu_valid SHALL be set to 0 and the other alu_* outputs SHALL hold their values.
REQ-025 Dispatch and issue in the same cycle SHALL both take effect; a slot freed by issue SHALL NOT be reused by dispatch in that cycle, and full SHALL be computed before the issue.
REQ-026 Latency: an entry dispatched with both operands ready at edge N SHALL issue (alu_valid=1) at edge N+1; an entry woken by the CDB at edge N SHALL issue at edge N+1 at the earliest.
REQ-027 Entries SHALL be selected by index, not by age; a starved entry is acceptable.

Reset
REQ-028 While rst_in=0, the block SHALL immediately, without waiting for a clock edge, clear all busy bits, set alu_valid=0, and set every other alu_* output to 0; full SHALL then read 0.
REQ-029 Reset SHALL take precedence over rdy_in and clear; the first dispatch after release SHALL go to entry 0.

Verification
REQ-030 Dispatch with in_qi_busy=0, in_qj_busy=0, in_vi=5, in_vj=3, op=000, op_type=0110011, rob=2 at edge N -> at edge N+1: alu_valid=1, alu_vi=5, alu_vj=3, alu_rob_entry=2; one cycle later: alu_valid=0.
REQ-031 Dispatch with qi_busy=1, qi=7, then cdb_valid=1, cdb_rob=7, cdb_val=0x1234 two cycles later -> issue one edge after the broadcast with alu_vi=0x1234; same test with the CDB in the dispatch cycle -> bypass, issue at N+1.
REQ-032 Fill all 8 entries with operands blocked on tag 9 -> full=1; a 9th in_valid is dropped; cdb_rob=9 -> entries issue in index order 0..7, one per cycle, and full drops after the first issue.
REQ-033 clear=1 while 3 entries are busy and alu_valid=1 -> next edge: full=0, alu_valid=0, no later issue; a CDB with the old tags causes no issue.
REQ-034 Hold rdy_in=0 for 4 cycles with a ready entry and a CDB pulse -> outputs frozen, CDB lost; rdy_in=1 -> issue resumes.
REQ-035 Pulse rst_in low mid-issue, asynchronously between clock edges -> alu_valid=0 and full=0 immediately, before the next clock edge.
